// File: rtl/pixel_fb_scanout.sv
// 160x120x3 framebuffer written by the drawing logic, scanned out as 640x480@60 VGA
// with each stored pixel replicated 4x4. Single 50 MHz clock, pixel tick every other cycle.
module pixel_fb_scanout #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       VGA_CLK,
   output logic       frame_done
);

   localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_DEPTH = FB_W * FB_H;

   logic        r_pix_en;
   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic [14:0] r_rd_addr;
   logic        r_s1_hs;
   logic        r_s1_vs;
   logic        r_s1_vis;
   logic        r_frame_done;
   logic [2:0]  r_rd_data;
   logic [2:0]  r_fb [0:FB_DEPTH-1];

   logic        w_vis;
   logic        w_hs_n;
   logic        w_vs_n;
   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [14:0] w_rd_addr;
   logic        w_wr_en;
   logic [14:0] w_wr_addr;

   assign w_vis    = (r_h_cnt < 10'(H_VIS)) && (r_v_cnt < 10'(V_VIS));
   assign w_hs_n   = !((r_h_cnt >= 10'(H_VIS + H_FP)) && (r_h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
   assign w_vs_n   = !((r_v_cnt >= 10'(V_VIS + V_FP)) && (r_v_cnt < 10'(V_VIS + V_FP + V_SYNC)));
   assign w_h_wrap = (r_h_cnt == 10'(H_TOT - 1));
   assign w_v_wrap = (r_v_cnt == 10'(V_TOT - 1));

   // Counter >> 2 gives the 4x4 pixel replication; blanked pixels read address 0.
   assign w_rd_addr = w_vis ? (15'(r_v_cnt[9:2]) * 15'(FB_W) + 15'(r_h_cnt[9:2])) : '0;

   assign w_wr_en   = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
   assign w_wr_addr = 15'(y) * 15'(FB_W) + 15'(x);

   assign VGA_SYNC_N = 1'b0;
   // Data changes on tick edges; pix_en rises on the edge between them, mid-pixel.
   assign VGA_CLK    = r_pix_en;
   assign frame_done = r_frame_done;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_pix_en     <= 1'b0;
         r_h_cnt      <= '0;
         r_v_cnt      <= '0;
         r_rd_addr    <= '0;
         r_s1_hs      <= 1'b1;
         r_s1_vs      <= 1'b1;
         r_s1_vis     <= 1'b0;
         r_frame_done <= 1'b0;
         VGA_R        <= '0;
         VGA_G        <= '0;
         VGA_B        <= '0;
         VGA_HS       <= 1'b1;
         VGA_VS       <= 1'b1;
         VGA_BLANK_N  <= 1'b0;
      end else begin
         r_pix_en     <= ~r_pix_en;
         r_frame_done <= 1'b0;
         if (r_pix_en) begin
            if (w_h_wrap) begin
               r_h_cnt <= '0;
               r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
               if (r_v_cnt == 10'(V_VIS - 1))
                  r_frame_done <= 1'b1;
            end else begin
               r_h_cnt <= r_h_cnt + 10'd1;
            end
            // Stage 1: address and flags; RAM reads during the idle cycle between ticks.
            r_rd_addr   <= w_rd_addr;
            r_s1_hs     <= w_hs_n;
            r_s1_vs     <= w_vs_n;
            r_s1_vis    <= w_vis;
            // Stage 2: colour expansion with blanking, flags kept aligned.
            VGA_R       <= (r_s1_vis && r_rd_data[2]) ? 8'hFF : 8'h00;
            VGA_G       <= (r_s1_vis && r_rd_data[1]) ? 8'hFF : 8'h00;
            VGA_B       <= (r_s1_vis && r_rd_data[0]) ? 8'hFF : 8'h00;
            VGA_HS      <= r_s1_hs;
            VGA_VS      <= r_s1_vs;
            VGA_BLANK_N <= r_s1_vis;
         end
      end
   end

   // Framebuffer: no reset, contents survive resetn; read-before-write on collisions.
   always_ff @(posedge CLOCK_50) begin
      if (w_wr_en)
         r_fb[w_wr_addr] <= colour;
      r_rd_data <= r_fb[r_rd_addr];
   end

endmodule

// File: tb/tb_pixel_fb_scanout.sv
// Bench for pixel_fb_scanout: shortened vertical timing so whole frames fit the run;
// outputs are compared every clock against a time-indexed raster model.
module tb_pixel_fb_scanout;

   localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
   localparam int TV_VIS = 12, TV_FP = 2, TV_SYNC = 2, TV_BP = 2;
   localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT    = TV_VIS + TV_FP + TV_SYNC + TV_BP;
   localparam int FRAME = HT * VT;

   logic       clk;
   logic       resetn;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_done;

   int         vectors = 0;
   int         miscompares = 0;
   int         ecount;
   logic [2:0] fb_model [0:19199];

   pixel_fb_scanout #(
      .V_VIS(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Clock edges seen since the last reset release.
   always @(posedge clk) ecount <= resetn ? ecount + 1 : 0;

   // Edge e shows raster pixel e/2-2 (two-tick pipeline, first tick on edge 2).
   function automatic logic [29:0] expect_out(int e);
      int q, pos, h, v;
      logic hs, vs, bn, fd, ck;
      logic [2:0] c;
      q  = e / 2 - 2;
      ck = (e % 2) == 1;
      fd = (e >= 2) && (e % 2 == 0) && (((e / 2 - 1) % FRAME) == TV_VIS * HT - 1);
      hs = 1'b1; vs = 1'b1; bn = 1'b0; c = 3'b000;
      if (q >= 0) begin
         pos = q % FRAME;
         h   = pos % HT;
         v   = pos / HT;
         hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
         vs  = !(v >= TV_VIS + TV_FP && v < TV_VIS + TV_FP + TV_SYNC);
         bn  = (h < H_VIS) && (v < TV_VIS);
         if (bn) c = fb_model[(v / 4) * 160 + h / 4];
      end
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, bn, fd, ck, 1'b0};
   endfunction

   task automatic check_cycles(input int n, input string tag);
      logic [29:0] obs, exp;
      repeat (n) begin
         @(negedge clk);
         obs = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_done, VGA_CLK, VGA_SYNC_N};
         exp = expect_out(ecount);
         vectors++;
         assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s e=%0d got %h exp %h", tag, ecount, obs, exp);
         end
      end
   endtask

   task automatic wr(input int wx, input int wy, input logic [2:0] wc);
      x = 8'(wx); y = 7'(wy); colour = wc; plot = 1'b1;
      @(negedge clk);
      if (wx < 160 && wy < 120) fb_model[wy * 160 + wx] = wc;
   endtask

   initial begin
      int guard, q, pos;
      for (int i = 0; i < 19200; i++) fb_model[i] = 3'b000;
      resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;

      // Reset values, then blank raster (syncs, blanking, zero RGB).
      check_cycles(3, "reset");
      resetn = 1'b1;
      check_cycles(1700, "blank_line");

      // Sustained raster of writes, one per cycle.
      for (int wy = 0; wy < 120; wy++)
         for (int wx = 0; wx < 160; wx++)
            wr(wx, wy, 3'((wx + wy) & 7));

      // Corners, back-to-back same address, out-of-range drops, random traffic.
      wr(0, 0, 3'b100);
      wr(159, 119, 3'b011);
      wr(159, 2, 3'b011);
      wr(3, 1, 3'b101);
      wr(3, 1, 3'b010);
      wr(160, 1, 3'b111);
      wr(200, 0, 3'b111);
      wr(5, 120, 3'b111);
      wr(255, 127, 3'b111);
      for (int i = 0; i < 40; i++)
         wr(int'($urandom_range(159)), int'($urandom_range(2)), 3'($urandom));
      for (int i = 0; i < 20; i++)
         wr(int'($urandom_range(255)), int'($urandom_range(127)), 3'($urandom));
      plot = 1'b0;
      repeat (8) @(negedge clk);

      // Two full frames: pixels, syncs, frame_done spacing.
      check_cycles(2 * FRAME, "frame");

      // Reset in the middle of visible line 6.
      guard = 0;
      q = ecount / 2 - 2; pos = q % FRAME;
      while (!(pos / HT == 6 && pos % HT == 300) && guard < 40000) begin
         @(negedge clk);
         guard++;
         q = ecount / 2 - 2; pos = q % FRAME;
      end
      vectors++;
      assert (guard < 40000) else begin
         miscompares++;
         $error("FAIL wait_line6 got %0d cycles exp <40000", guard);
      end
      resetn = 1'b0;
      check_cycles(5, "mid_reset");
      resetn = 1'b1;
      check_cycles(3 * HT * 2, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
